// File: rtl/eta_pkg.sv
// rtl/eta_pkg.sv - shared mode encoding and default sizes for the ETA approximate adder
package eta_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  localparam int DEF_W     = 16;
  localparam int DEF_K     = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/eta_approx_core.sv
// rtl/eta_approx_core.sv - combinational ETA-style approximate adder with exact reference
module eta_approx_core
  import eta_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = DEF_K
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         mismatch
);

  logic [W:0]   exact;
  logic [W:0]   approx;
  logic [K-1:0] lo;
  logic         c;

  assign exact = {1'b0, a} + {1'b0, b};
  assign c     = a[K-1] & b[K-1];

  // Low part: each bit only sees the generate term of its immediate neighbour.
  always_comb begin
    lo    = '0;
    lo[0] = a[0] | b[0];
    for (int i = 1; i < K; i++) begin
      lo[i] = a[i] | b[i] | (a[i-1] & b[i-1]);
    end
  end

  generate
    if (K < W) begin : g_hi
      logic [W-K:0] hi;
      assign hi     = {1'b0, a[W-1:K]} + {1'b0, b[W-1:K]} + {{(W-K){1'b0}}, c};
      assign approx = {hi, lo};
    end else begin : g_nohi
      assign approx = {c, lo};
    end
  endgenerate

  always_comb begin
    {cout, s} = (mode == MODE_APPROX) ? approx : exact;
    mismatch  = (mode == MODE_APPROX) && (approx != exact);
  end

endmodule

// File: rtl/eta_approx_adder_pipe.sv
// rtl/eta_approx_adder_pipe.sv - two-stage valid/ready pipeline around the approximate adder
module eta_approx_adder_pipe
  import eta_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int K     = DEF_K,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     s,
  output logic             cout,
  output logic             mismatch,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic         v1, v2;
  logic [W-1:0] a1, b1;
  logic         m1;
  logic [W-1:0] core_s;
  logic         core_cout, core_mm;
  logic         s2_free, adv1, in_fire, out_fire;

  assign s2_free   = !v2 || out_ready;
  assign adv1      = v1 && s2_free;
  assign in_ready  = !v1 || s2_free;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = v2 && out_ready;
  assign out_valid = v2;

  eta_approx_core #(.W(W), .K(K)) u_core (
    .a        (a1),
    .b        (b1),
    .mode     (m1),
    .s        (core_s),
    .cout     (core_cout),
    .mismatch (core_mm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      a1       <= '0;
      b1       <= '0;
      m1       <= MODE_EXACT;
      s        <= '0;
      cout     <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (in_fire) begin
        a1 <= a;
        b1 <= b;
        m1 <= mode;
      end
      v1 <= in_fire || (v1 && !s2_free);
      // Result registers only move on a stage-1 advance, so they hold while stalled.
      if (adv1) begin
        s        <= core_s;
        cout     <= core_cout;
        mismatch <= core_mm;
      end
      v2 <= adv1 || (v2 && !out_ready);
      if (clr_cnt) begin
        err_cnt <= '0;
      end else if (out_fire && mismatch && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eta_approx_adder_pipe.sv
// tb/tb_eta_approx_adder_pipe.sv - directed self-checking bench for eta_approx_adder_pipe
module tb_eta_approx_adder_pipe;

  localparam int W = 16;
  localparam int K = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a, b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     s;
  logic             cout;
  logic             mismatch;
  logic             clr_cnt;
  logic [CNT_W-1:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  eta_approx_adder_pipe #(.W(W), .K(K), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .mismatch  (mismatch),
    .clr_cnt   (clr_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One transaction with out_ready high; optional clr_cnt during its output transfer.
  task automatic txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic tm, input logic [W-1:0] es, input logic ec,
                     input logic emm, input logic clr);
    bit seen = 0;
    @(negedge clk);
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; a = ta; b = tb; mode = tm;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_out_valid"}, seen, 1);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_mm"}, mismatch, emm);
    clr_cnt = clr;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0;
    out_ready = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_mm", mismatch, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    txn("ap_ff_01", 16'h00FF, 16'h0001, 1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0);
    chk("cnt_1", err_cnt, 1);
    txn("ap_80_80", 16'h0080, 16'h0080, 1'b1, 16'h0180, 1'b0, 1'b1, 1'b0);
    chk("cnt_2", err_cnt, 2);
    txn("ap_1200_34", 16'h1200, 16'h0034, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    chk("cnt_2_hold", err_cnt, 2);
    txn("ex_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("cnt_exact_hold", err_cnt, 2);
    txn("ap_ffff_1", 16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    chk("cnt_3", err_cnt, 3);
    txn("ap_ff_01b", 16'h00FF, 16'h0001, 1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0);
    txn("ap_80_80b", 16'h0080, 16'h0080, 1'b1, 16'h0180, 1'b0, 1'b1, 1'b0);
    chk("cnt_sat", err_cnt, 3);
    txn("ap_clr", 16'h0080, 16'h0080, 1'b1, 16'h0180, 1'b0, 1'b1, 1'b1);
    chk("cnt_clr", err_cnt, 0);

    // Backpressure: three offers, only two fit, results drain in order.
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_rdy0", in_ready, 1);
    in_valid = 1'b1; a = 16'h0001; b = 16'h0002; mode = 1'b0;
    @(negedge clk);
    chk("bp_rdy1", in_ready, 1);
    a = 16'h00FF; b = 16'h0001; mode = 1'b1;
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; mode = 1'b0;
    chk("bp_rdy2", in_ready, 0);
    chk("bp_ov", out_valid, 1);
    chk("bp_s1", s, 16'h0003);
    @(negedge clk);
    chk("bp_rdy3", in_ready, 0);
    chk("bp_s1_hold", s, 16'h0003);
    chk("bp_mm1_hold", mismatch, 0);
    out_ready = 1'b1;
    #1 chk("bp_rdy_comb", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_s2", s, 16'h00FF);
    chk("bp_mm2", mismatch, 1);
    @(negedge clk);
    chk("bp_s3", s, 16'h0300);
    chk("bp_mm3", mismatch, 0);
    chk("bp_ov3", out_valid, 1);
    chk("bp_cnt", err_cnt, 1);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h0080; b = 16'h0080; mode = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("mid_ov_before", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ov", out_valid, 0);
    chk("mid_cnt", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_no_stale", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eta_approx_adder_pipe.md
ETA_APPROX_ADDER_PIPE -- requirements
Module: eta_approx_adder_pipe

Interface
REQ-001 Parameter: W, 16, operand/sum width in bits, legal 2..64.
REQ-002 Parameter: K, 8, width of approximate low part, legal 1..W.
REQ-003 Parameter: CNT_W, 16, width of the mismatch counter.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: in_valid  input  1  operand transaction offered.
REQ-007 Port: in_ready  output  1  block accepts operands this cycle.
REQ-008 Port: a, b  input  W each  operands.
REQ-009 Port: mode  input  1  0 = exact add, 1 = approximate add; sampled with the operands.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer takes result this cycle.
REQ-012 Port: s  output  W  sum.
REQ-013 Port: cout  output  1  carry out.
REQ-014 Port: mismatch  output  1  presented result differs from exact {cout,s}.
REQ-015 Port: clr_cnt  input  1  synchronous clear of err_cnt.
REQ-016 Port: err_cnt  output  CNT_W  saturating count of mismatching results delivered.

Function
REQ-017 Approximate low part: s[0] = a[0] | b[0]; for 1 <= i < K: s[i] = a[i] | b[i] | (a[i-1] & b[i-1]).
REQ-018 Approximate high part: s[W-1:K] and cout = exact sum of a[W-1:K] + b[W-1:K] + c, where c = a[K-1] & b[K-1].
REQ-019 Approximate mode with K = W: cout = a[W-1] & b[W-1].
REQ-020 Exact mode: {cout,s} = a + b, full W+1-bit result.
REQ-021 The exact sum is always computed alongside; mismatch = approximate mode and {cout,s} != exact result; mismatch = 0 in exact mode.
REQ-022 Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
REQ-023 Pipeline: stage 1 registers a, b and mode; stage 2 registers s, cout and mismatch; an accepted operand appears at the outputs 2 cycles later when not stalled.
REQ-024 Full throughput: 1 transaction per cycle with out_ready held high.
REQ-025 Stall: a stage advances only if its successor is empty or is transferring in the same cycle.
REQ-026 in_ready = stage 1 empty or stage 1 advancing; it is combinational from out_ready.
REQ-027 Capacity: 2 transactions in flight; with out_ready low, at most 2 inputs are accepted, then in_ready = 0.
REQ-028 While out_valid = 1 and out_ready = 0, s, cout and mismatch hold stable.
REQ-029 Transactions are never dropped, duplicated or reordered.
REQ-030 err_cnt increments by 1 on each output transfer with mismatch = 1 and saturates at 2^CNT_W - 1.
REQ-031 If clr_cnt is high, err_cnt = 0 next cycle, even when an increment coincides.
REQ-032 Changing mode between transactions affects only newly accepted transactions.

Reset
REQ-033 While rst is high, at the next clk edge: both stages empty, out_valid = 0, err_cnt = 0, s = 0, cout = 0, mismatch = 0.
REQ-034 Reset mid-operation discards all in-flight transactions; in_ready = 1 from the first cycle after rst deasserts.

Structure
REQ-035 Shared package eta_pkg holds the mode encoding constants (MODE_EXACT = 0, MODE_APPROX = 1) and the default W, K and CNT_W values.
REQ-036 One combinational sub-module, eta_approx_core (params W, K), implements REQ-017..REQ-021.
REQ-037 Handshake, stage registers and counter live in eta_approx_adder_pipe.

Verification (W = 16, K = 8)
REQ-038 Approximate mode, a = 0x00FF, b = 0x0001 -> s = 0x00FF, cout = 0, mismatch = 1, err_cnt 0 -> 1.
REQ-039 Approximate mode, a = 0x0080, b = 0x0080 -> s = 0x0180, mismatch = 1; a = 0x1200, b = 0x0034 -> s = 0x1234, mismatch = 0, err_cnt unchanged.
REQ-040 Exact mode, a = 0xFFFF, b = 0x0001 -> s = 0x0000, cout = 1, mismatch = 0.
REQ-041 Backpressure: out_ready low, 3 transactions offered back-to-back -> 2 accepted, then in_ready = 0 and outputs stable; after out_ready rises, all 3 results arrive in order.
REQ-042 CNT_W = 2: 5 mismatching transfers -> err_cnt = 3 (saturated); clr_cnt together with a mismatching transfer -> err_cnt = 0.
REQ-043 rst asserted with 2 transactions in flight -> out_valid = 0 and err_cnt = 0 the next cycle; no stale result after release.
